// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetcher with a DEPTH-entry return queue. Request at t, data at t+1, head valid at t+2.
// Requests are credit-limited (count + in-flight < DEPTH); a redirect flushes everything and refetches at the target.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     IM_req,
    output logic [31:0]              IM_addr,
    input  logic [31:0]              IM_rdata,
    input  logic                     EX_redirect,
    input  logic [31:0]              EX_target,
    input  logic                     DU_pop,
    output logic                     IFQ_valid,
    output logic [31:0]              IFQ_Instr,
    output logic [31:0]              IFQ_PC,
    output logic [$clog2(DEPTH):0]   IFQ_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc;
    logic            inflight_q;
    logic [31:0]     inflight_pc;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_q, count_d;
    ifq_entry_t      queue_mem [DEPTH];

    logic            head_vld;
    logic            room;
    logic            im_req;
    logic            push;
    logic            pop;
    logic [CW:0]     credits_used;

    assign head_vld     = (count_q != '0);
    assign credits_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign room         = (credits_used < DEPTH_W);

    // Redirect outranks both queue ports: the returning word and any pop are discarded.
    assign push = inflight_q && !EX_redirect;
    assign pop  = DU_pop && head_vld && !EX_redirect;

    always_comb begin
        count_d = count_q;
        if (EX_redirect) begin
            count_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        im_req  = 1'b0;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                im_req = room;
                if (!EX_redirect && !room)
                    state_d = FULL;
            end
            FULL: begin
                if (EX_redirect || ({1'b0, count_d} < DEPTH_W))
                    state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc    <= {RESET_PC[31:2], 2'b00};
            inflight_q  <= 1'b0;
            inflight_pc <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (EX_redirect) begin
                fetch_pc   <= {EX_target[31:2], 2'b00};
                inflight_q <= 1'b0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
            end else begin
                inflight_q <= im_req;
                if (im_req) begin
                    inflight_pc <= fetch_pc;
                    fetch_pc    <= fetch_pc + 32'd4;
                end
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst)
            queue_mem[wr_ptr] <= '{pc: inflight_pc, instr: IM_rdata};
    end

    // The credit rule must make this unreachable.
    assert property (@(posedge clk) disable iff (rst) !(push && !pop && count_q == CW'(DEPTH)));

    // Outputs are forced idle while reset is held, not only after the reset edge.
    assign IM_req    = im_req && !rst;
    assign IM_addr   = fetch_pc;
    assign IFQ_valid = head_vld && !rst;
    assign IFQ_Instr = (head_vld && !rst) ? queue_mem[rd_ptr].instr : NOP;
    assign IFQ_PC    = (head_vld && !rst) ? queue_mem[rd_ptr].pc : 32'h0;
    assign IFQ_count = rst ? '0 : count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        IM_req;
    logic [31:0] IM_addr;
    logic [31:0] IM_rdata = 32'hDEAD_BEEF;
    logic        EX_redirect;
    logic [31:0] EX_target;
    logic        DU_pop;
    logic        IFQ_valid;
    logic [31:0] IFQ_Instr;
    logic [31:0] IFQ_PC;
    logic [2:0]  IFQ_count;

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .NOP(32'h13)) dut (
        .clk(clk), .rst(rst),
        .IM_req(IM_req), .IM_addr(IM_addr), .IM_rdata(IM_rdata),
        .EX_redirect(EX_redirect), .EX_target(EX_target),
        .DU_pop(DU_pop),
        .IFQ_valid(IFQ_valid), .IFQ_Instr(IFQ_Instr), .IFQ_PC(IFQ_PC),
        .IFQ_count(IFQ_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
    endfunction

    // Fixed one-cycle instruction memory.
    always @(posedge clk)
        IM_rdata <= IM_req ? pat(IM_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc;
        int          nv;
        bit          seen;

        rst = 1'b1; EX_redirect = 1'b0; EX_target = '0; DU_pop = 1'b0;
        tick(); tick();
        chk("rst_req",   32'(IM_req), 32'd0);
        chk("rst_valid", 32'(IFQ_valid), 32'd0);
        chk("rst_instr", IFQ_Instr, 32'h13);
        chk("rst_pc",    IFQ_PC, 32'h0);
        chk("rst_count", 32'(IFQ_count), 32'd0);
        rst = 1'b0;
        chk("post_rst_req", 32'(IM_req), 32'd0);

        // Fill from reset: four back-to-back requests then stall.
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("fill_req",  32'(IM_req), 32'd1);
            chk("fill_addr", IM_addr, 32'(4 * i));
            if (i == 1) chk("fill_valid_early", 32'(IFQ_valid), 32'd0);
            if (i == 2) begin
                chk("fill_valid", 32'(IFQ_valid), 32'd1);
                chk("fill_head_pc", IFQ_PC, 32'h0);
            end
            tick();
        end
        chk("full_req", 32'(IM_req), 32'd0);
        tick();
        chk("full_count", 32'(IFQ_count), 32'd4);
        chk("full_req2",  32'(IM_req), 32'd0);
        chk("full_head_instr", IFQ_Instr, pat(32'h0));

        // Single pop from full gives exactly one new request.
        DU_pop = 1'b1;
        tick();
        DU_pop = 1'b0;
        chk("pop1_count", 32'(IFQ_count), 32'd3);
        chk("pop1_pc",    IFQ_PC, 32'h4);
        chk("pop1_req",   32'(IM_req), 32'd1);
        chk("pop1_addr",  IM_addr, 32'h10);
        tick();
        chk("pop1_req_after", 32'(IM_req), 32'd0);
        tick();
        chk("pop1_refill_count", 32'(IFQ_count), 32'd4);

        // Steady state: pop every cycle, one instruction per cycle.
        DU_pop = 1'b1;
        exp_pc = 32'h4;
        nv = 0;
        for (int i = 0; i < 16; i++) begin
            if (IFQ_valid) begin
                chk("steady_pc",    IFQ_PC, exp_pc);
                chk("steady_instr", IFQ_Instr, pat(exp_pc));
                exp_pc += 32'd4;
                nv++;
            end
            tick();
        end
        chk("steady_rate", 32'(nv), 32'd16);

        // Redirect with count=2 and a response in flight.
        chk("pre_redir_count", 32'(IFQ_count), 32'd2);
        DU_pop = 1'b0;
        EX_redirect = 1'b1; EX_target = 32'h103;
        tick();
        EX_redirect = 1'b0;
        chk("redir_valid", 32'(IFQ_valid), 32'd0);
        chk("redir_count", 32'(IFQ_count), 32'd0);
        chk("redir_req",   32'(IM_req), 32'd1);
        chk("redir_addr",  IM_addr, 32'h100);
        tick();
        chk("redir_addr2",  IM_addr, 32'h104);
        chk("redir_valid2", 32'(IFQ_valid), 32'd0);
        tick();
        chk("redir_head_pc",    IFQ_PC, 32'h100);
        chk("redir_head_instr", IFQ_Instr, pat(32'h100));

        // Redirect with pop, then a second redirect: last one wins.
        DU_pop = 1'b1;
        EX_redirect = 1'b1; EX_target = 32'h200;
        tick();
        DU_pop = 1'b0;
        EX_target = 32'h300;
        chk("dbl_count1", 32'(IFQ_count), 32'd0);
        chk("dbl_valid1", 32'(IFQ_valid), 32'd0);
        tick();
        EX_redirect = 1'b0;
        chk("dbl_count2", 32'(IFQ_count), 32'd0);
        chk("dbl_valid2", 32'(IFQ_valid), 32'd0);
        chk("dbl_addr",   IM_addr, 32'h300);
        tick();
        chk("dbl_addr2",  IM_addr, 32'h304);
        chk("dbl_valid3", 32'(IFQ_valid), 32'd0);
        tick();
        chk("dbl_head_pc", IFQ_PC, 32'h300);

        // Reset mid-stream at count=3.
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (IFQ_count == 3'd3) seen = 1'b1;
            else tick();
        end
        chk("reach_count3", 32'(seen), 32'd1);
        rst = 1'b1;
        tick();
        chk("mrst_count", 32'(IFQ_count), 32'd0);
        chk("mrst_instr", IFQ_Instr, 32'h13);
        chk("mrst_req",   32'(IM_req), 32'd0);
        chk("mrst_valid", 32'(IFQ_valid), 32'd0);
        rst = 1'b0;
        chk("mrst_idle_req", 32'(IM_req), 32'd0);
        tick();
        chk("mrst_restart_req",   32'(IM_req), 32'd1);
        chk("mrst_restart_addr",  IM_addr, 32'h0);
        chk("mrst_restart_count", 32'(IFQ_count), 32'd0);
        tick(); tick();
        chk("mrst_head_pc",    IFQ_PC, 32'h0);
        chk("mrst_head_instr", IFQ_Instr, pat(32'h0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Front-end producer for the decoding unit. Generates sequential fetch PCs to a fixed-latency instruction memory, buffers returned instructions with their PCs in a DEPTH-entry FIFO, and presents the head entry as IFQ_Instr / IFQ_PC.
- Branch/jump redirects from the execute stage flush the queue and restart fetch at the target.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP, 32'h0000_0013, value driven on IFQ_Instr when the queue is empty (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- IM_req  output  1  fetch request to instruction memory.
- IM_addr  output  32  fetch address; word aligned, IM_addr[1:0]=0.
- IM_rdata  input  32  instruction word, valid exactly 1 cycle after the IM_req cycle.
- EX_redirect  input  1  taken branch or jump; flush and refetch.
- EX_target  input  32  redirect address; bits [1:0] ignored and forced to 0.
- DU_pop  input  1  decoder consumes the head entry this cycle; ignored when IFQ_valid=0.
- IFQ_valid  output  1  head entry valid.
- IFQ_Instr  output  32  head instruction, or NOP when empty.
- IFQ_PC  output  32  PC of the head instruction, or 0 when empty.
- IFQ_count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (synchronous, rst=1 at the edge):
  - fetch_pc=RESET_PC, queue empty, in-flight flag cleared, rd/wr pointers = 0.
  - Outputs during reset and the cycle after: IM_req=0, IFQ_valid=0, IFQ_Instr=NOP, IFQ_PC=0, IFQ_count=0.
  - Reset mid-operation drops all queued and in-flight instructions. Memory data returning in the cycle after reset is discarded.
- State (internal FSM, 2 bits):
  - IDLE: held by reset. After rst deasserts, go to FETCH on the next edge.
  - FETCH: IM_req=1 when IFQ_count + inflight < DEPTH. On the request edge: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0). If the request condition is false, go to FULL.
  - FULL: IM_req=0. Return to FETCH on the edge where a pop makes IFQ_count + inflight < DEPTH.
  - EX_redirect moves FULL to FETCH.
- IM_addr = fetch_pc whenever IM_req=1; don't-care otherwise (drive fetch_pc).
- Return path:
  - If inflight=1 at an edge, {inflight_pc, IM_rdata} is written at wr_ptr and inflight clears, unless a new request issues on that edge.
  - Back-to-back requests give 1 instruction per cycle.
- Latency: request at cycle t -> data on IM_rdata at t+1 -> IFQ_valid with that entry at t+2. No bypass from IM_rdata to IFQ_Instr.
- Outputs: IFQ_Instr, IFQ_PC and IFQ_valid come from the head register/array only, combinationally from rd_ptr.
- Pop: DU_pop with IFQ_valid=1 advances rd_ptr. Pop and push on the same edge leave count unchanged.
- Full: a push never happens when IFQ_count=DEPTH, guaranteed by the credit rule. A push attempted at full is a bug; flag it with an assertion.
- Redirect, which has highest priority:
  - On an edge with EX_redirect=1: the queue empties (pointers reset, count=0), inflight clears, and the returning IM_rdata is dropped.
  - fetch_pc <= {EX_target[31:2], 2'b00}. A same-cycle DU_pop and any push are ignored.
  - The redirect cycle itself may show IM_req=1 for the old fetch_pc. That response is dropped by the cleared inflight flag.
  - The first request to the target issues the cycle after the redirect.
  - Redirects on consecutive cycles: the last one wins.

Test Plan:
- Reset release, RESET_PC=0, DU_pop=0, DEPTH=4 -> IM_addr 0x0,0x4,0x8,0xC on four consecutive cycles, then IM_req=0. IFQ_valid rises 2 cycles after the first request with IFQ_PC=0x0. IFQ_count settles at 4.
- Full queue, pulse DU_pop one cycle -> exactly one new request at 0x10. Count goes 4->3->4. IFQ_PC advances 0x0->0x4.
- Steady state, DU_pop=1 every cycle, IM_rdata=PC-dependent pattern -> one instruction per cycle. IFQ_PC sequence 0,4,8,... with no gaps or duplicates, and IFQ_Instr matches the pattern.
- EX_redirect=1, EX_target=0x103 while inflight=1 and count=2 -> next cycle IFQ_valid=0, count=0, IM_addr=0x100. The dropped data never appears. The first valid IFQ_PC is 0x100.
- EX_redirect and DU_pop together, plus a redirect on two consecutive cycles (0x200 then 0x300) -> the queue stays empty and fetch resumes at 0x300 only.
- rst asserted mid-stream with count=3 -> next cycle count=0, IFQ_Instr=0x00000013, IM_req=0. After release, fetch restarts at RESET_PC.
